// File: rtl/scr_base_l3_bk_tp_arb.sv
// L3 bank tag pipe issue arbiter: retry buffer > snoop > request, credit-limited, registered d0 issue.
// Optional: SCR_L3_TP_ARB_RR_EN shares the snoop/request slot round-robin instead of fixed priority.
module scr_base_l3_bk_tp_arb #(
  parameter int SCRID_W    = 4,
  parameter int TXNID_W    = 8,
  parameter int OPC_W      = 5,
  parameter int ADDR_W     = 40,
  parameter int RTRY_DEPTH = 4,
  localparam int CNT_W     = $clog2(RTRY_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_val_i,
  output logic               req_rdy_o,
  input  logic [SCRID_W-1:0] req_scrid_i,
  input  logic [TXNID_W-1:0] req_txnid_i,
  input  logic [OPC_W-1:0]   req_opc_i,
  input  logic [ADDR_W-1:0]  req_addr_i,
  input  logic               snp_val_i,
  output logic               snp_rdy_o,
  input  logic [SCRID_W-1:0] snp_scrid_i,
  input  logic [TXNID_W-1:0] snp_txnid_i,
  input  logic [OPC_W-1:0]   snp_opc_i,
  input  logic [ADDR_W-1:0]  snp_addr_i,
  output logic               d0_val_o,
  output logic               d0_req_val_o,
  output logic               d0_snp_val_o,
  output logic               d0_retry_o,
  output logic [SCRID_W-1:0] d0_scrid_o,
  output logic [TXNID_W-1:0] d0_txnid_o,
  output logic [OPC_W-1:0]   d0_opc_o,
  output logic [ADDR_W-1:0]  d0_addr_o,
  input  logic               d4_val_i,
  input  logic               d4_req_val_i,
  input  logic               d4_snp_val_i,
  input  logic               d4_need_retry_i,
  input  logic [SCRID_W-1:0] d4_scrid_i,
  input  logic [TXNID_W-1:0] d4_txnid_i,
  input  logic [OPC_W-1:0]   d4_opc_i,
  input  logic [ADDR_W-1:0]  d4_addr_i,
  output logic [CNT_W-1:0]   rtry_cnt_o,
  output logic               idle_o
);

  localparam int PTR_W = (RTRY_DEPTH > 1) ? $clog2(RTRY_DEPTH) : 1;

  typedef struct packed {
    logic               is_snp;
    logic [SCRID_W-1:0] scrid;
    logic [TXNID_W-1:0] txnid;
    logic [OPC_W-1:0]   opc;
    logic [ADDR_W-1:0]  addr;
  } rtry_ent_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_RTRY,
    SRC_SNP,
    SRC_REQ
  } src_e;

  rtry_ent_t        mem [RTRY_DEPTH];
  rtry_ent_t        head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] rtry_cnt;
  logic [CNT_W-1:0] ifl;
  logic [CNT_W:0]   occ_sum;
  logic             rtry_empty;
  logic             rtry_full;
  logic             credit;
  logic             base_rdy;
  logic             push;
  logic             pop;
  logic             ifl_inc;
  src_e             gnt_src;

  logic               sel_req;
  logic               sel_snp;
  logic [SCRID_W-1:0] sel_scrid;
  logic [TXNID_W-1:0] sel_txnid;
  logic [OPC_W-1:0]   sel_opc;
  logic [ADDR_W-1:0]  sel_addr;

  // Only d4_snp_val_i is needed to classify a retry; the request qualifier is implied.
  logic unused_d4_req_val;
  assign unused_d4_req_val = d4_req_val_i;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RTRY_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign head       = mem[rd_ptr];
  assign rtry_empty = (rtry_cnt == '0);
  assign rtry_full  = (rtry_cnt == CNT_W'(RTRY_DEPTH));
  assign occ_sum    = {1'b0, rtry_cnt} + {1'b0, ifl};
  assign credit     = (occ_sum < (CNT_W+1)'(RTRY_DEPTH));
  assign base_rdy   = credit & rtry_empty;

`ifdef SCR_L3_TP_ARB_RR_EN
  logic rr_ptr_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_req <= 1'b0;
    end else if (gnt_src == SRC_SNP) begin
      rr_ptr_req <= 1'b1;
    end else if (gnt_src == SRC_REQ) begin
      rr_ptr_req <= 1'b0;
    end
  end

  assign snp_rdy_o = base_rdy & (~req_val_i | ~rr_ptr_req);
  assign req_rdy_o = base_rdy & (~snp_val_i | rr_ptr_req);
`else
  assign snp_rdy_o = base_rdy;
  assign req_rdy_o = base_rdy & ~snp_val_i;
`endif

  always_comb begin
    gnt_src = SRC_NONE;
    if (!rtry_empty) begin
      gnt_src = SRC_RTRY;
    end else if (snp_val_i && snp_rdy_o) begin
      gnt_src = SRC_SNP;
    end else if (req_val_i && req_rdy_o) begin
      gnt_src = SRC_REQ;
    end
  end

  assign push    = d4_val_i & d4_need_retry_i;
  assign pop     = (gnt_src == SRC_RTRY);
  assign ifl_inc = (gnt_src != SRC_NONE);

  always_comb begin
    sel_req   = 1'b0;
    sel_snp   = 1'b0;
    sel_scrid = req_scrid_i;
    sel_txnid = req_txnid_i;
    sel_opc   = req_opc_i;
    sel_addr  = req_addr_i;
    case (gnt_src)
      SRC_RTRY: begin
        sel_req   = ~head.is_snp;
        sel_snp   = head.is_snp;
        sel_scrid = head.scrid;
        sel_txnid = head.txnid;
        sel_opc   = head.opc;
        sel_addr  = head.addr;
      end
      SRC_SNP: begin
        sel_snp   = 1'b1;
        sel_scrid = snp_scrid_i;
        sel_txnid = snp_txnid_i;
        sel_opc   = snp_opc_i;
        sel_addr  = snp_addr_i;
      end
      SRC_REQ: begin
        sel_req = 1'b1;
      end
      default: begin
        sel_req = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{is_snp: d4_snp_val_i, scrid: d4_scrid_i, txnid: d4_txnid_i,
                       opc: d4_opc_i, addr: d4_addr_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rtry_cnt <= '0;
      ifl      <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop) begin
        rtry_cnt <= rtry_cnt + CNT_W'(1);
      end else if (pop && !push) begin
        rtry_cnt <= rtry_cnt - CNT_W'(1);
      end
      if (ifl_inc && !d4_val_i) begin
        ifl <= ifl + CNT_W'(1);
      end else if (d4_val_i && !ifl_inc) begin
        ifl <= ifl - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d0_val_o     <= 1'b0;
      d0_req_val_o <= 1'b0;
      d0_snp_val_o <= 1'b0;
      d0_retry_o   <= 1'b0;
      d0_scrid_o   <= '0;
      d0_txnid_o   <= '0;
      d0_opc_o     <= '0;
      d0_addr_o    <= '0;
    end else begin
      d0_val_o     <= ifl_inc;
      d0_req_val_o <= sel_req;
      d0_snp_val_o <= sel_snp;
      d0_retry_o   <= pop;
      if (ifl_inc) begin
        d0_scrid_o <= sel_scrid;
        d0_txnid_o <= sel_txnid;
        d0_opc_o   <= sel_opc;
        d0_addr_o  <= sel_addr;
      end
    end
  end

  assign rtry_cnt_o = rtry_cnt;
  assign idle_o     = rtry_empty & (ifl == '0);

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && rtry_full));
  a_no_d4_idle:   assert property (@(posedge clk) disable iff (!rst_n) !(d4_val_i && (ifl == '0)));

endmodule
